// File: rtl/posit16_1_pkg.sv
// Shared constants and pipeline stage record for the posit<16,1> quire
// converter.
package posit16_1_pkg;

    localparam int QUIRE_W    = 128;
    localparam int QUIRE_FRAC = 56;
    localparam int N          = 16;
    localparam int ES         = 1;

    // Magnitude width: the sign bit is gone once the quire is made positive.
    localparam int PAY_W      = QUIRE_W - 1;
    // Fraction bits kept below the hidden bit after normalisation.
    localparam int FRAC_KEEP  = 70;

    localparam logic [15:0] MAXPOS = 16'h7FFF;
    localparam logic [15:0] MINPOS = 16'h0001;
    localparam logic [15:0] NAR    = 16'h8000;

    // Scale of the MSB position of the magnitude (bit PAY_W-1).
    localparam logic signed [7:0] SCALE_TOP = 8'sd70;
    localparam logic signed [7:0] SCALE_MAX = 8'sd28;
    localparam logic signed [7:0] SCALE_MIN = -8'sd28;

    typedef struct packed {
        logic             valid;
        logic             sow;
        logic             eow;
        logic             nar;
        logic             zero;
        logic             sign;
        logic [PAY_W-1:0] payload;
    } stage_t;

endpackage

// File: rtl/quire16_1_to_posit_lzc128.sv
// Leading-zero counter over a 127-bit vector; all-zero input returns 127.
module lzc128 (
    input  logic [126:0] vec,
    output logic [6:0]   cnt
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        cnt = 7'd127;
        for (int i = 0; i < 127; i++) begin
            if (vec[i]) cnt = 7'(126 - i);
        end
    end

endmodule

// File: rtl/quire16_1_to_posit.sv
// 4-stage quire -> posit<16,1> converter with a single global stall.
// S1 capture/abs, S2 leading-zero count, S3 normalise, S4 encode and round.
module quire16_1_to_posit #(
    parameter int QUIRE_W = 128,
    parameter int N       = 16,
    parameter int ES      = 1
) (
    input  logic               tb_clk,
    input  logic               tb_reset_n,
    input  logic               rts_i,
    output logic               rtr_o,
    input  logic               sow_i,
    input  logic               eow_i,
    input  logic [QUIRE_W-1:0] data_i,
    output logic               rts_o,
    input  logic               rtr_i,
    output logic               sow_o,
    output logic               eow_o,
    output logic [N-1:0]       posit_o
);

    import posit16_1_pkg::*;

    localparam int BW = 16 + ES + FRAC_KEEP;

    logic                 en;
    stage_t               s1, s2, s3;
    logic [6:0]           lzc, s2_lzc;
    logic signed [7:0]    s2_scale, s3_scale;
    logic [FRAC_KEEP-1:0] frac_c;

    logic signed [4:0]    k;
    logic [ES-1:0]        e;
    logic [3:0]           nk;
    logic [15:0]          rg16;
    logic [4:0]           reg_len;
    logic [BW-1:0]        body;
    logic [14:0]          top;
    logic                 guard, sticky, inc;
    logic [15:0]          rnd, mag, res;

    // The whole pipe advances unless a valid result is being held back.
    assign en    = ~rts_o | rtr_i;
    assign rtr_o = en;

    // S1: capture, classify and take the absolute value.
    always_ff @(posedge tb_clk or negedge tb_reset_n) begin
        if (!tb_reset_n) begin
            s1 <= '0;
        end else if (en) begin
            s1.valid   <= rts_i;
            s1.sow     <= rts_i & sow_i;
            s1.eow     <= rts_i & eow_i;
            s1.nar     <= data_i == {1'b1, {(QUIRE_W-1){1'b0}}};
            s1.zero    <= data_i == '0;
            s1.sign    <= data_i[QUIRE_W-1];
            s1.payload <= PAY_W'(data_i[QUIRE_W-1] ? -data_i : data_i);
        end
    end

    lzc128 u_lzc (
        .vec (s1.payload),
        .cnt (lzc)
    );

    // S2: register the leading-zero count and the resulting binary scale.
    always_ff @(posedge tb_clk or negedge tb_reset_n) begin
        if (!tb_reset_n) begin
            s2       <= '0;
            s2_lzc   <= '0;
            s2_scale <= '0;
        end else if (en) begin
            s2       <= s1;
            s2_lzc   <= lzc;
            s2_scale <= SCALE_TOP - $signed({1'b0, lzc});
        end
    end

    // Shift out the leading zeros and the hidden bit; keep the top fraction bits.
    // Zero input wraps the shift amount, but zero bypasses the arithmetic.
    always_comb begin
        frac_c = FRAC_KEEP'((s2.payload << (s2_lzc + 7'd1)) >> (PAY_W - FRAC_KEEP));
    end

    // S3: register the normalised fraction, left-aligned in the payload.
    always_ff @(posedge tb_clk or negedge tb_reset_n) begin
        if (!tb_reset_n) begin
            s3       <= '0;
            s3_scale <= '0;
        end else if (en) begin
            s3         <= s2;
            s3.payload <= {frac_c, {(PAY_W-FRAC_KEEP){1'b0}}};
            s3_scale   <= s2_scale;
        end
    end

    // S4 datapath: build regime/exponent/fraction, round to nearest even,
    // saturate to maxpos/minpos and apply the sign.
    always_comb begin
        k       = 5'(s3_scale >>> ES);
        e       = s3_scale[ES-1:0];
        nk      = '0;
        rg16    = '0;
        reg_len = '0;
        if (!k[4]) begin
            rg16    = ~(16'hFFFF >> (k[3:0] + 4'd1));
            reg_len = {1'b0, k[3:0]} + 5'd2;
        end else begin
            nk      = 4'(-k);
            rg16    = 16'h8000 >> nk;
            reg_len = {1'b0, nk} + 5'd1;
        end
        body   = {rg16, {(BW-16){1'b0}}}
               | ({e, s3.payload[PAY_W-1 -: FRAC_KEEP], 16'd0} >> reg_len);
        top    = body[BW-1 -: 15];
        guard  = body[BW-16];
        sticky = (|body[BW-17:0]) | (|s3.payload[PAY_W-FRAC_KEEP-1:0]);
        inc    = guard & (top[0] | sticky);
        rnd    = {1'b0, top} + {15'd0, inc};
        if (s3_scale >= SCALE_MAX || rnd[15]) mag = MAXPOS;
        else if (s3_scale < SCALE_MIN)        mag = MINPOS;
        else                                  mag = rnd;
        if (s3.nar)       res = NAR;
        else if (s3.zero) res = '0;
        else if (s3.sign) res = -mag;
        else              res = mag;
    end

    // S4: output register, held while downstream stalls.
    always_ff @(posedge tb_clk or negedge tb_reset_n) begin
        if (!tb_reset_n) begin
            rts_o   <= 1'b0;
            sow_o   <= 1'b0;
            eow_o   <= 1'b0;
            posit_o <= '0;
        end else if (en) begin
            rts_o   <= s3.valid;
            sow_o   <= s3.sow;
            eow_o   <= s3.eow;
            posit_o <= N'(res);
        end
    end

endmodule

// File: doc/quire16_1_to_posit.md
# quire16_1_to_posit

Converts the 128-bit posit<16,1> quire produced by the quire16_1 accumulator into a rounded 16-bit posit<16,1>. It sits directly downstream of quire16_1 and consumes its rts/rtr/sow/eow stream and data word. The result stream uses the same handshake for the next stage, such as a posit packer or AXI-stream sink. The block is a 4-stage pipeline with global stall on backpressure.

## Interface
Parameters:
- QUIRE_W, 128, quire width; fixed for posit<16,1>.
- N, 16, posit width.
- ES, 1, exponent size.

Ports:
- tb_clk  in  1  clock
- tb_reset_n  in  1  reset, asynchronous, active-low
- rts_i  in  1  input word valid
- rtr_o  out  1  ready for input
- sow_i  in  1  start of window, qualified by rts_i
- eow_i  in  1  end of window, qualified by rts_i
- data_i  in  128  quire, two's complement
- rts_o  out  1  output valid
- rtr_i  in  1  downstream ready
- sow_o  out  1  sow_i delayed alongside data
- eow_o  out  1  eow_i delayed alongside data
- posit_o  out  16  rounded posit

## Operation
Quire format:
- Bit 127 is the sign.
- Bits [126:112] are the carry guard.
- Bits [111:56] are the integer part.
- Bits [55:0] are the fraction; LSB weight is 2^-56.
- NaR is 128'h8000_0000_..._0000.

Stages:
- S1: capture the word. Flag NaR (exact pattern) and zero (all bits 0). Form the magnitude (negate when bit 127 = 1) and register the sign.
- S2: run a leading-zero count on magnitude[126:0]. scale = (126 − lzc) − 56, giving a signed 8-bit range of −56..70.
- S3: left-shift the magnitude so the hidden bit is dropped. Keep 70 fraction bits, zero-padded.
- S4: encode the posit.
  - k = scale >>> 1 (floor) and e = scale[0].
  - Regime: k ≥ 0 gives k+1 ones then a 0; k < 0 gives −k zeros then a 1.
  - Body = {regime, e, fraction}. Take the top 15 bits, guard = next bit, sticky = OR of the remaining bits.
  - Round to nearest, ties to even: increment when guard & (lsb | sticky).
  - Apply the sign by two's-complementing the 16-bit result.

Special cases:
- NaR → 16'h8000.
- Zero → 16'h0000.
- scale ≥ 28, or rounding carries into bit 15 → magnitude 16'h7FFF (maxpos).
- scale < −28 → magnitude 16'h0001 (minpos). A nonzero quire never rounds to zero.
- NaR and zero bypass the arithmetic via flags carried down the pipeline.

## Timing
Reset:
- All outputs are 0 at reset: rts_o=0, sow_o=0, eow_o=0, posit_o=16'h0000.
- rtr_o reflects the combinational rule below (1 once the pipeline is empty).
- Stage valid bits clear asynchronously on tb_reset_n low. An in-flight word is discarded, with no partial output after release.

Latency and throughput:
- Latency is 4 cycles from an accepted input (rts_i & rtr_o at the edge) to rts_o.
- Throughput is 1 word/cycle when rtr_i is held 1.

Handshake:
- Global enable: en = ~rts_o | rtr_i, and rtr_o = en.
- When en = 0, every stage holds; posit_o, sow_o and eow_o stay stable while rts_o = 1.
- An input that is offered while rtr_o = 0 is not consumed. The upstream block must hold it.
- Bubbles (rts_i = 0 with en = 1) propagate as invalid stages.
- sow and eow travel with their word; a single-word window carries sow_o = eow_o = 1.

## Structure
- posit16_1_pkg holds:
  - QUIRE_W=128, QUIRE_FRAC=56, N=16, ES=1.
  - MAXPOS=16'h7FFF, MINPOS=16'h0001, NAR=16'h8000.
  - Scale limits ±28.
  - A stage struct typedef {valid, sow, eow, nar, zero, sign, payload}.
- One sub-module: lzc128, a combinational leading-zero counter over 127 bits with a 7-bit output, instantiated in S2.

## Test plan
- Specials: data_i = 1<<56 (1.0) → 16'h4000 after 4 cycles; its negation → 16'hC000; 128'h0 → 16'h0000; the NaR pattern → 16'h8000.
- Fraction and rounding at 1.0:
  - 1.5 (3<<55) → 16'h4800.
  - 1+2^-13 (tie) → 16'h4000.
  - 1+3·2^-13 → 16'h4002.
- Saturation:
  - 2^40 → 16'h7FFF.
  - −2^40 → 16'h8001.
  - data_i = 1 (2^-56) → 16'h0001.
  - −1 → 16'hFFFF.
- Streaming: 8 back-to-back words with sow on the first and eow on the last, rtr_i = 1. Outputs arrive in order on 8 consecutive cycles starting at cycle 4, with sow_o and eow_o aligned.
- Backpressure: drop rtr_i for 3 cycles mid-stream. rtr_o falls in the same cycle, posit_o holds stable, and no word is lost or duplicated.
- Reset mid-stream: assert tb_reset_n low with 3 words in flight. rts_o drops to 0 immediately, and after release the first new word emerges 4 cycles after acceptance.
